// File: rtl/item_pkg.sv
// item_pkg: shared constants and types for the item scan sequencer.
//   ITEM_X / ITEM_Y : world position of each item slot (up to 16 slots)
//   BOX_DEFAULT     : default box extent in pixels
//   scan_state_t    : sequencer state encoding
package item_pkg;

    localparam int BOX_DEFAULT = 12;
    localparam int MAX_ITEMS   = 16;

    localparam logic [9:0] ITEM_X [MAX_ITEMS] = '{
        10'd180, 10'd260, 10'd400, 10'd520, 10'd600, 10'd640, 10'd700, 10'd760,
        10'd820, 10'd880, 10'd940, 10'd40,  10'd100, 10'd160, 10'd220, 10'd280
    };

    localparam logic [9:0] ITEM_Y [MAX_ITEMS] = '{
        10'd290, 10'd290, 10'd250, 10'd300, 10'd280, 10'd260, 10'd240, 10'd300,
        10'd290, 10'd270, 10'd250, 10'd200, 10'd210, 10'd220, 10'd230, 10'd240
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_STALL
    } scan_state_t;

endpackage

// File: rtl/item_evq.sv
// item_evq: synchronous valid/ready FIFO for touch-event slot indices.
//   clk, rst        : clock, asynchronous active-high reset
//   flush           : empties the queue (priority over push/pop)
//   push, push_data : write request and 4-bit slot index; accepted when
//                     not full, or when full with a pop in the same cycle
//   valid, head     : queue head (registered storage)
//   ready           : consumer takes the head on valid & ready
//   full, empty     : occupancy flags
module item_evq #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  logic [3:0] push_data,
    input  logic       ready,
    output logic       valid,
    output logic [3:0] head,
    output logic       full,
    output logic       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [3:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          pop;
    logic          do_push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign valid   = !empty;
    assign head    = mem[rd_ptr];
    assign pop     = valid & ready;
    assign do_push = push & (!full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/item_scan_ctrl.sv
// item_scan_ctrl: once per frame tick, walks every item slot with a single
// shared box comparator, retires touched slots and queues their indices.
// Also serves scrolled item coordinates to the renderer.
//   sys_clk, RST          : clock, asynchronous active-high reset
//   frame_tick            : starts a scan (ignored and flagged while busy)
//   char_X, char_Y        : character world position, latched at scan start
//   bg_pos                : background scroll offset for rd_x
//   ev_valid/ev_idx/ev_ready : touch-event queue head handshake
//   rd_idx -> rd_x/rd_y/rd_en : combinational renderer read port
//   item_en               : per-slot enable vector
//   scan_busy, scan_done, overrun : status
//   lvl_restart           : exists only when ITEM_RESPAWN_EN is defined;
//                           re-enables all slots, flushes events, aborts scan
module item_scan_ctrl
    import item_pkg::*;
#(
    parameter int N_ITEMS   = 4,
    parameter int EVQ_DEPTH = 4,
    parameter int BOX       = BOX_DEFAULT
) (
    input  logic               sys_clk,
    input  logic               RST,
    input  logic               frame_tick,
    input  logic [9:0]         char_X,
    input  logic [9:0]         char_Y,
    input  logic [9:0]         bg_pos,
    output logic               ev_valid,
    output logic [3:0]         ev_idx,
    input  logic               ev_ready,
    input  logic [3:0]         rd_idx,
    output logic [9:0]         rd_x,
    output logic [9:0]         rd_y,
    output logic               rd_en,
    output logic [N_ITEMS-1:0] item_en,
`ifdef ITEM_RESPAWN_EN
    input  logic               lvl_restart,
`endif
    output logic               scan_busy,
    output logic               scan_done,
    output logic               overrun
);

    scan_state_t state;
    logic [3:0]  idx;
    logic [9:0]  cx, cy;
    logic [15:0] en_ext;
    logic [15:0] idx_mask;
    logic [10:0] bx, ix, iy, cxw, cyw;
    logic        hit, last, full, empty, pop, push, restart;

    assign en_ext   = 16'(item_en);
    assign idx_mask = 16'd1 << idx;
    assign last     = (idx == 4'(N_ITEMS - 1));
    assign pop      = ev_valid & ev_ready;

`ifdef ITEM_RESPAWN_EN
    assign restart = lvl_restart;
`else
    assign restart = 1'b0;
`endif

    // 11-bit sums so pos+BOX never wraps near the 1023 edge.
    assign bx  = 11'(BOX);
    assign ix  = {1'b0, ITEM_X[idx]};
    assign iy  = {1'b0, ITEM_Y[idx]};
    assign cxw = {1'b0, cx};
    assign cyw = {1'b0, cy};
    assign hit = en_ext[idx] & (cxw + bx >= ix) & (cxw <= ix + bx)
                             & (cyw + bx >= iy) & (cyw <= iy + bx);

    // In STALL the pending slot is pushed only when a pop makes room.
    assign push = !restart & (((state == S_SCAN) & hit & !full) |
                              ((state == S_STALL) & pop));

    item_evq #(.DEPTH(EVQ_DEPTH)) u_evq (
        .clk       (sys_clk),
        .rst       (RST),
        .flush     (restart),
        .push      (push),
        .push_data (idx),
        .ready     (ev_ready),
        .valid     (ev_valid),
        .head      (ev_idx),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge sys_clk or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            idx       <= '0;
            cx        <= '0;
            cy        <= '0;
            item_en   <= '1;
            scan_busy <= 1'b0;
            scan_done <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (restart) begin
                state     <= S_IDLE;
                idx       <= '0;
                item_en   <= '1;
                scan_busy <= 1'b0;
            end else begin
                if (frame_tick & scan_busy) overrun <= 1'b1;
                case (state)
                    S_IDLE: begin
                        if (frame_tick) begin
                            state     <= S_SCAN;
                            scan_busy <= 1'b1;
                            idx       <= '0;
                            cx        <= char_X;
                            cy        <= char_Y;
                        end
                    end
                    S_SCAN, S_STALL: begin
                        if ((state == S_SCAN) & hit & full) begin
                            state <= S_STALL;
                        end else if ((state == S_SCAN) | pop) begin
                            if (push) item_en <= item_en & ~idx_mask[N_ITEMS-1:0];
                            if (last) begin
                                state     <= S_IDLE;
                                scan_busy <= 1'b0;
                                scan_done <= 1'b1;
                            end else begin
                                state <= S_SCAN;
                                idx   <= idx + 1'b1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign rd_x  = ITEM_X[rd_idx] - bg_pos;
    assign rd_y  = ITEM_Y[rd_idx];
    assign rd_en = en_ext[rd_idx];

endmodule
